// File: rtl/stream_rx_fifo_if.sv
// Handshake bundle between the delay-line stream, the receive FIFO and its consumer.
// The o_drop_cnt member exists only when RX_DROP_CNT_EN is defined.
interface stream_rx_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]         i_data;
    logic                     i_valid;
    logic                     i_ready;
    logic [WIDTH-1:0]         o_data;
    logic                     o_valid;
    logic                     o_full;
    logic [$clog2(DEPTH):0]   o_level;
    logic                     o_overflow;
`ifdef RX_DROP_CNT_EN
    logic [7:0]               o_drop_cnt;
`endif

`ifdef RX_DROP_CNT_EN
    modport master (output i_data, i_valid, i_ready,
                    input  o_data, o_valid, o_full, o_level, o_overflow, o_drop_cnt);
    modport slave  (input  i_data, i_valid, i_ready,
                    output o_data, o_valid, o_full, o_level, o_overflow, o_drop_cnt);
`else
    modport master (output i_data, i_valid, i_ready,
                    input  o_data, o_valid, o_full, o_level, o_overflow);
    modport slave  (input  i_data, i_valid, i_ready,
                    output o_data, o_valid, o_full, o_level, o_overflow);
`endif
endinterface

// File: rtl/stream_rx_fifo.sv
// Show-ahead receive FIFO with no upstream backpressure; words arriving while full are dropped.
// Define RX_DROP_CNT_EN to add the saturating 8-bit dropped-word counter (o_drop_cnt).
module stream_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    stream_rx_fifo_if.slave  bus
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wrPtr_q, wrPtr_d;
    logic [PW-1:0]    rdPtr_q, rdPtr_d;
    logic [LW-1:0]    level_q, level_d;
    logic             overflow_q, overflow_d;
    logic             empty, full, doRead, doWrite, doDrop;

    // Pointers wrap explicitly so that DEPTH need not be a power of two.
    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        empty      = (level_q == '0);
        full       = (level_q == LW'(DEPTH));
        doRead     = !empty && bus.i_ready;
        doWrite    = bus.i_valid && (!full || doRead);
        doDrop     = bus.i_valid && full && !doRead;
        wrPtr_d    = wrPtr_q;
        rdPtr_d    = rdPtr_q;
        level_d    = level_q;
        overflow_d = overflow_q || doDrop;
        if (doWrite) wrPtr_d = nextPtr(wrPtr_q);
        if (doRead)  rdPtr_d = nextPtr(rdPtr_q);
        case ({doWrite, doRead})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wrPtr_q    <= wrPtr_d;
            rdPtr_q    <= rdPtr_d;
            level_q    <= level_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately not reset; empty-state output masking hides stale words.
    always_ff @(posedge clk) begin
        if (!rst && doWrite) begin
            mem[wrPtr_q] <= bus.i_data;
        end
    end

    assign bus.o_data     = empty ? '0 : mem[rdPtr_q];
    assign bus.o_valid    = !empty;
    assign bus.o_full     = full;
    assign bus.o_level    = level_q;
    assign bus.o_overflow = overflow_q;

`ifdef RX_DROP_CNT_EN
    logic [7:0] dropCnt_q, dropCnt_d;

    always_comb begin
        dropCnt_d = dropCnt_q;
        if (doDrop && (dropCnt_q != 8'hFF)) dropCnt_d = dropCnt_q + 8'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) dropCnt_q <= '0;
        else     dropCnt_q <= dropCnt_d;
    end

    assign bus.o_drop_cnt = dropCnt_q;
`endif
endmodule

// File: tb/tb_stream_rx_fifo.sv
// Directed self-checking bench for stream_rx_fifo (DEPTH=4, WIDTH=8).
// Drop-count checks are included when RX_DROP_CNT_EN is defined.
module tb_stream_rx_fifo;
    logic clk;
    logic rst;
    int   compared;
    int   mismatched;

    stream_rx_fifo_if #(.WIDTH(8), .DEPTH(4)) bus ();

    stream_rx_fifo #(.WIDTH(8), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Inputs are applied, then one rising edge passes; outputs are sampled 1ns later.
    task automatic applyStimulus(input logic valid, input logic [7:0] data, input logic ready);
        bus.i_valid = valid;
        bus.i_data  = data;
        bus.i_ready = ready;
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0);
        rst = 1'b0;
    endtask

    task automatic fillFour();
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        bus.i_valid = 1'b0;
        bus.i_data  = 8'h00;
        bus.i_ready = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0);
        doReset();

        checkOutput("rst_valid", bus.o_valid, 0);
        checkOutput("rst_full", bus.o_full, 0);
        checkOutput("rst_level", bus.o_level, 0);
        checkOutput("rst_ovf", bus.o_overflow, 0);
        checkOutput("rst_data", bus.o_data, 0);
`ifdef RX_DROP_CNT_EN
        checkOutput("rst_dropcnt", bus.o_drop_cnt, 0);
`endif

        applyStimulus(1'b1, 8'h11, 1'b0);
        checkOutput("single_valid", bus.o_valid, 1);
        checkOutput("single_data", bus.o_data, 32'h11);
        checkOutput("single_level", bus.o_level, 1);

        doReset();
        fillFour();
        checkOutput("fill_full", bus.o_full, 1);
        checkOutput("fill_level", bus.o_level, 4);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("hold_data", bus.o_data, 32'h01);
        for (int i = 1; i <= 4; i++) begin
            checkOutput("drain_data", bus.o_data, 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("drain_level", bus.o_level, 0);
        checkOutput("drain_valid", bus.o_valid, 0);
        checkOutput("drain_ovf", bus.o_overflow, 0);

        doReset();
        fillFour();
        applyStimulus(1'b1, 8'h55, 1'b0);
        checkOutput("drop_ovf", bus.o_overflow, 1);
        checkOutput("drop_level", bus.o_level, 4);
        checkOutput("drop_full", bus.o_full, 1);
        checkOutput("drop_data", bus.o_data, 32'h01);
`ifdef RX_DROP_CNT_EN
        checkOutput("drop_cnt", bus.o_drop_cnt, 1);
`endif
        for (int i = 1; i <= 4; i++) begin
            checkOutput("dropdrain_data", bus.o_data, 32'(i));
            applyStimulus(1'b0, 8'h00, 1'b1);
        end
        checkOutput("dropdrain_valid", bus.o_valid, 0);
        checkOutput("dropdrain_ovf_sticky", bus.o_overflow, 1);

        doReset();
        fillFour();
        applyStimulus(1'b1, 8'h66, 1'b1);
        checkOutput("fullrw_level", bus.o_level, 4);
        checkOutput("fullrw_full", bus.o_full, 1);
        checkOutput("fullrw_ovf", bus.o_overflow, 0);
        begin
            logic [7:0] expSeq [4];
            expSeq = '{8'h02, 8'h03, 8'h04, 8'h66};
            for (int i = 0; i < 4; i++) begin
                checkOutput("fullrw_drain", bus.o_data, 32'(expSeq[i]));
                applyStimulus(1'b0, 8'h00, 1'b1);
            end
        end
        checkOutput("fullrw_empty", bus.o_valid, 0);

        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 8'(8'h10 + i), 1'b1);
            checkOutput("stream_valid", bus.o_valid, 1);
            checkOutput("stream_data", bus.o_data, 32'(8'h10 + i));
            checkOutput("stream_level", bus.o_level, 1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1);
        checkOutput("stream_end_level", bus.o_level, 0);

        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'(8'hA0 + i), 1'b0);
        checkOutput("mid_level", bus.o_level, 3);
        rst = 1'b1;
        applyStimulus(1'b1, 8'h77, 1'b0);
        rst = 1'b0;
        checkOutput("midrst_level", bus.o_level, 0);
        checkOutput("midrst_valid", bus.o_valid, 0);
        checkOutput("midrst_ovf", bus.o_overflow, 0);
        checkOutput("midrst_data", bus.o_data, 0);
        applyStimulus(1'b0, 8'h00, 1'b0);
        checkOutput("midrst_nowrite", bus.o_level, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
